// File: rtl/uart_tx_frame.sv
// uart_tx_frame: 8N1 UART transmitter, one byte per valid/ready handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_oe,
  output logic       busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] timer;
  logic [2:0]       idx;
  logic [7:0]       shift;
  logic             last;
`ifdef UART_TX_PARITY_EN
  logic             par;
`endif

  assign last = (timer == LAST);

  // Bit timer: runs in every non-idle state, clears as each bit ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (state == IDLE || last) begin
      timer <= '0;
    end else begin
      timer <= timer + CNT_W'(1);
    end
  end

  // Pad enable comes up on the first edge after reset and stays up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_oe <= 1'b0;
    end else begin
      tx_oe <= 1'b1;
    end
  end

  // Frame sequencer: owns state, shift register and all line outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 3'd0;
      shift    <= 8'd0;
      tx_out   <= 1'b1;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          idx      <= 3'd0;
          tx_out   <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          if (tx_valid && tx_ready) begin
            state    <= START;
            shift    <= tx_data;
`ifdef UART_TX_PARITY_EN
            par      <= ^tx_data;
`endif
            tx_out   <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (last) begin
            state  <= DATA;
            tx_out <= shift[0];
          end
        end
        DATA: begin
          if (last) begin
            if (idx == 3'd7) begin
              idx    <= 3'd0;
`ifdef UART_TX_PARITY_EN
              state  <= PARITY;
              tx_out <= par;
`else
              state  <= STOP;
              tx_out <= 1'b1;
`endif
            end else begin
              idx    <= idx + 3'd1;
              shift  <= {1'b0, shift[7:1]};
              tx_out <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (last) begin
            state  <= STOP;
            tx_out <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (last) begin
            state    <= IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          idx      <= 3'd0;
          tx_out   <= 1'b1;
          tx_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
